// File: rtl/lcd_char_writer.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_char_writer
//  Purpose  : Runs the HD44780 init sequence after power-on, then rewrites a
//             four-character field at LINE_ADDR whenever the keypad display
//             buffer differs from what was last written to the glass.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_char_writer #(
  parameter int         PWR_DLY   = 60000,
  parameter int         CMD_DLY   = 160,
  parameter int         CLR_DLY   = 6560,
  parameter int         E_HIGH    = 2,
  parameter logic [6:0] LINE_ADDR = 7'h00
) (
  input  logic       clk_4MHz,
  input  logic       rst_n,
  input  logic [7:0] display_value [0:3],
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       init_done,
  output logic       busy
);

  // One shared delay counter, wide enough for the longest wait it must time.
  localparam int c_max_a   = (PWR_DLY > CLR_DLY) ? PWR_DLY : CLR_DLY;
  localparam int c_max_b   = (CMD_DLY > E_HIGH)  ? CMD_DLY : E_HIGH;
  localparam int c_max_dly = (c_max_a > c_max_b) ? c_max_a : c_max_b;
  localparam int c_cnt_w   = $clog2(c_max_dly + 1);

  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_pwr_last = c_cnt_w'(PWR_DLY - 1);
  localparam logic [c_cnt_w-1:0] c_cmd_last = c_cnt_w'(CMD_DLY - 1);
  localparam logic [c_cnt_w-1:0] c_clr_last = c_cnt_w'(CLR_DLY - 1);
  localparam logic [c_cnt_w-1:0] c_e_last   = c_cnt_w'(E_HIGH - 1);

  // Top-level sequencing states
  localparam logic [2:0] c_st_pwr_wait = 3'd0;
  localparam logic [2:0] c_st_init     = 3'd1;
  localparam logic [2:0] c_st_idle     = 3'd2;
  localparam logic [2:0] c_st_addr     = 3'd3;
  localparam logic [2:0] c_st_char     = 3'd4;

  // Bus-engine phases of a single byte transfer
  localparam logic [1:0] c_ph_setup  = 2'd0;
  localparam logic [1:0] c_ph_strobe = 2'd1;
  localparam logic [1:0] c_ph_hold   = 2'd2;
  localparam logic [1:0] c_ph_wait   = 2'd3;

  logic [2:0]         r_state;
  logic [1:0]         r_phase;
  logic [c_cnt_w-1:0] r_cnt;
  logic [1:0]         r_idx;
  logic               r_lcd_e;
  logic               r_lcd_rs;
  logic [7:0]         r_lcd_data;
  logic               r_init_done;
  logic               r_force;
  logic [7:0]         r_shadow [0:3];

  logic               w_mismatch;
  logic [c_cnt_w-1:0] w_wait_last;
  logic               w_done;
  logic [1:0]         w_idx_inc;
  logic               w_launch;
  logic               w_launch_rs;
  logic [7:0]         w_launch_byte;
  logic [2:0]         w_nstate;
  logic [1:0]         w_nidx;
  logic               w_capture;

  // Controller init commands: 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] f_init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    f_init_cmd = 8'h38;
      2'd1:    f_init_cmd = 8'h0C;
      2'd2:    f_init_cmd = 8'h01;
      default: f_init_cmd = 8'h06;
    endcase
  endfunction

  // Next-transfer selection: decides when a new byte is launched and which one.
  always_comb begin
    w_mismatch    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (display_value[i] != r_shadow[i]) w_mismatch = 1'b1;
    end
    // Only the clear-display command needs the long wait.
    w_wait_last   = (!r_lcd_rs && (r_lcd_data == 8'h01)) ? c_clr_last : c_cmd_last;
    w_done        = (r_phase == c_ph_wait) && (r_cnt == w_wait_last);
    w_idx_inc     = r_idx + 2'd1;
    w_launch      = 1'b0;
    w_launch_rs   = 1'b0;
    w_launch_byte = 8'h00;
    w_nstate      = r_state;
    w_nidx        = r_idx;
    w_capture     = 1'b0;
    case (r_state)
      c_st_pwr_wait: begin
        if (r_cnt == c_pwr_last) begin
          w_launch      = 1'b1;
          w_launch_byte = f_init_cmd(2'd0);
          w_nstate      = c_st_init;
          w_nidx        = 2'd0;
        end
      end
      c_st_init: begin
        if (w_done) begin
          if (r_idx == 2'd3) begin
            w_nstate = c_st_idle;
          end else begin
            w_launch      = 1'b1;
            w_launch_byte = f_init_cmd(w_idx_inc);
            w_nidx        = w_idx_inc;
          end
        end
      end
      c_st_idle: begin
        if (w_mismatch || r_force) begin
          w_capture     = 1'b1;
          w_launch      = 1'b1;
          w_launch_byte = {1'b1, LINE_ADDR};
          w_nstate      = c_st_addr;
        end
      end
      c_st_addr: begin
        if (w_done) begin
          w_launch      = 1'b1;
          w_launch_rs   = 1'b1;
          w_launch_byte = r_shadow[0];
          w_nstate      = c_st_char;
          w_nidx        = 2'd0;
        end
      end
      c_st_char: begin
        if (w_done) begin
          if (r_idx == 2'd3) begin
            w_nstate = c_st_idle;
          end else begin
            w_launch      = 1'b1;
            w_launch_rs   = 1'b1;
            w_launch_byte = r_shadow[w_idx_inc];
            w_nidx        = w_idx_inc;
          end
        end
      end
      default: w_nstate = c_st_pwr_wait;
    endcase
  end

  // Sequencer, bus engine and shadow register; reset aborts any transfer at once.
  always_ff @(posedge clk_4MHz) begin
    if (!rst_n) begin
      r_state     <= c_st_pwr_wait;
      r_phase     <= c_ph_setup;
      r_cnt       <= '0;
      r_idx       <= 2'd0;
      r_lcd_e     <= 1'b0;
      r_lcd_rs    <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_init_done <= 1'b0;
      r_force     <= 1'b1;
      for (int i = 0; i < 4; i++) r_shadow[i] <= 8'h20;
    end else begin
      r_state <= w_nstate;
      r_idx   <= w_nidx;
      if (w_nstate == c_st_idle) r_init_done <= 1'b1;
      if (w_capture) begin
        for (int i = 0; i < 4; i++) r_shadow[i] <= display_value[i];
        r_force <= 1'b0;
      end
      if (w_launch) begin
        // SETUP: present the byte with the strobe low.
        r_phase    <= c_ph_setup;
        r_cnt      <= '0;
        r_lcd_e    <= 1'b0;
        r_lcd_rs   <= w_launch_rs;
        r_lcd_data <= w_launch_byte;
      end else if (w_nstate != r_state) begin
        r_cnt <= '0;
      end else if (r_state == c_st_pwr_wait) begin
        r_cnt <= r_cnt + c_one;
      end else if (r_state != c_st_idle) begin
        case (r_phase)
          c_ph_setup: begin
            r_lcd_e <= 1'b1;
            r_phase <= c_ph_strobe;
            r_cnt   <= '0;
          end
          c_ph_strobe: begin
            if (r_cnt == c_e_last) begin
              r_lcd_e <= 1'b0;
              r_phase <= c_ph_hold;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + c_one;
            end
          end
          c_ph_hold: begin
            r_phase <= c_ph_wait;
            r_cnt   <= '0;
          end
          default: r_cnt <= r_cnt + c_one;
        endcase
      end
    end
  end

  assign lcd_rs    = r_lcd_rs;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = r_lcd_e;
  assign lcd_data  = r_lcd_data;
  assign init_done = r_init_done;
  assign busy      = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: doc/lcd_char_writer.md
# lcd_char_writer

Drives a character LCD with the four-character display buffer the keypad block produces (`display_value[0:3]`). It sits between the keypad block and the HD44780-compatible 8-bit parallel LCD port and is the reader side of that interface. After power-on it runs the controller init sequence, then rewrites the four characters at a fixed DDRAM address whenever the buffer content differs from what is currently on the glass.

## Interface
Parameters:
- `PWR_DLY`, 60000: power-on wait in clocks (15 ms at 4 MHz).
- `CMD_DLY`, 160: post-write wait for normal commands and data writes (40 µs).
- `CLR_DLY`, 6560: post-write wait after clear-display (1.64 ms).
- `E_HIGH`, 2: clocks `lcd_e` is held high (500 ns).
- `LINE_ADDR`, 7'h00: DDRAM address of the first character.

Ports:
- `clk_4MHz`  in  1  system clock. One clock domain only.
- `rst_n`  in  1  reset, synchronous and active-low.
- `display_value`  in  [7:0] x [0:3]  ASCII characters, index 0 leftmost.
- `lcd_rs`  out  1  0 = command, 1 = data.
- `lcd_rw`  out  1  tied 0 (write only).
- `lcd_e`  out  1  enable strobe.
- `lcd_data`  out  8  bus to LCD.
- `init_done`  out  1  high once the init sequence completes; stays high until reset.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Bus engine, one byte per transfer. SETUP: 1 clk, `lcd_rs`/`lcd_data` driven, `lcd_e`=0. STROBE: `E_HIGH` clks with `lcd_e`=1. HOLD: 1 clk with `lcd_e`=0 and data unchanged. WAIT: delay count (`CLR_DLY` for 8'h01, else `CMD_DLY`). `lcd_rs` and `lcd_data` keep their value until the next SETUP.
- Top FSM states: PWR_WAIT → INIT (4 commands: 8'h38, 8'h0C, 8'h01, 8'h06, in order) → IDLE → ADDR (command {1'b1, LINE_ADDR}) → CHAR (data bytes shadow[0]..shadow[3]) → IDLE.
- `init_done` rises on the cycle the FSM enters IDLE for the first time.
- In IDLE, each clock compares `display_value[0:3]` with the 32-bit `shadow`. On mismatch, or when the force flag is set:
  - copy `display_value` into `shadow`;
  - clear the force flag;
  - go to ADDR.
- The force flag is set by reset, so the first refresh after init always occurs.
- Characters are taken from `shadow` only, never from the live input mid-refresh. Input changes during a refresh are detected in IDLE afterwards, which triggers another refresh.
- Full refresh = 5 transfers. The address is re-sent every refresh, so no reliance on auto-increment state.

## Timing
- Reset values (`rst_n`=0 sampled at a clock edge):
  - state = PWR_WAIT, counters = 0;
  - `lcd_e`=0, `lcd_rs`=0, `lcd_rw`=0, `lcd_data`=8'h00;
  - `init_done`=0, `busy`=1;
  - `shadow`=all 8'h20, force flag=1.
- Reset mid-transfer aborts immediately, including with `lcd_e` high: `lcd_e` goes 0 on the next edge and the full `PWR_DLY` is repeated.
- PWR_WAIT lasts exactly `PWR_DLY` clocks after reset release.
- One transfer = 1 + `E_HIGH` + 1 + delay clocks. With defaults:
  - normal transfer: 164 clks;
  - clear: 6564 clks.
- Init total = `PWR_DLY` + 3·(`E_HIGH`+2+`CMD_DLY`) + (`E_HIGH`+2+`CLR_DLY`).
- Refresh latency: mismatch seen in IDLE at cycle N → ADDR SETUP at N+1. First `lcd_e` rise at N+2. Return to IDLE after 5·(`E_HIGH`+2+`CMD_DLY`) clks.
- IDLE re-arms in the same cycle it is entered. A pending mismatch starts the next refresh on the following cycle.
- Delay counter widths are sized from the parameters via `$clog2`. No wrap is permitted: each counter resets on every state entry.

## Test plan
Benches use `PWR_DLY`=20, `CMD_DLY`=5, `CLR_DLY`=12, `E_HIGH`=2.
- Reset, then release with input = "    " → exactly four command strobes, bytes 38,0C,01,06, `lcd_rs`=0. Gap after 01 is 12 wait clks. First `lcd_e` rise occurs 21 clks after release.
- After init with input "1234" → one refresh: 80 (rs=0), then 31,32,33,34 (rs=1). `busy` is high for exactly 5·9 clks. Afterwards `init_done`=1, `lcd_e`=0.
- Hold input constant for 500 clks after a refresh → zero `lcd_e` edges, `busy`=0.
- Change input from "1234" to "12m " during CHAR index 1 → current refresh still writes 31,32,33,34. The next refresh follows immediately and writes 80,31,32,6D,20.
- Assert `rst_n`=0 while `lcd_e`=1 → next edge gives `lcd_e`=0, `lcd_data`=00, `init_done`=0. After release the full init sequence repeats, then refresh.
- `LINE_ADDR`=7'h40, input "9KHz" → address byte C0, then 39,4B,48,7A; every STROBE is exactly 2 clks with data stable from SETUP through HOLD.
